// File: rtl/accel_sha256_pkg.sv
// SHA-256 message-schedule constants, scheduler state encoding and the small-sigma helpers
// shared by the scheduler and its expansion datapath.
package accel_sha256_pkg;

  localparam int NUM_ROUNDS  = 64;
  localparam int BLOCK_WORDS = 16;
  localparam int WORD_W      = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    START,
    FEED,
    WAIT
  } sched_state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] shr(input logic [WORD_W-1:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

endpackage

// File: rtl/accel_sched_expand.sv
// Combinational schedule expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
// Kept as its own block so the sigma/adder tree can be placed and timed in isolation.
module accel_sched_expand
  import accel_sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_m16,
  input  logic [WORD_W-1:0] w_m15,
  input  logic [WORD_W-1:0] w_m7,
  input  logic [WORD_W-1:0] w_m2,
  output logic [WORD_W-1:0] w_new
);

  assign w_new = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

endmodule

// File: rtl/accel_msg_scheduler.sv
// SHA-256 message scheduler: accepts a 512-bit block, pulses the compressor controls and
// streams W[0..63] one word per cycle, then waits for hash_done (with a sticky timeout).
module accel_msg_scheduler
  import accel_sha256_pkg::*;
#(
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          blk_valid,
  output logic                          blk_ready,
  input  logic [BLOCK_WORDS*WORD_W-1:0] blk_data,
  input  logic                          blk_first,
  output logic                          cm_init,
  output logic                          cm_enable,
  output logic [WORD_W-1:0]             w,
  output logic                          w_valid,
  output logic [5:0]                    w_idx,
  input  logic                          hash_done,
  output logic                          err_timeout
);

  localparam int               CNT_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [5:0]       T_LAST   = 6'(NUM_ROUNDS - 1);

  sched_state_t     state_reg, state_next;
  logic [WORD_W-1:0] window_reg   [BLOCK_WORDS];
  logic [WORD_W-1:0] window_load  [BLOCK_WORDS];
  logic [WORD_W-1:0] window_shift [BLOCK_WORDS];
  logic [WORD_W-1:0] w_new;
  logic [5:0]        t_reg, t_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              err_reg, err_next;
  logic              load, shift;

  // window[0] always holds W[t]; each FEED cycle the new W[t+16] enters at the tail.
  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_window
      assign window_load[gi] = blk_data[(BLOCK_WORDS - gi) * WORD_W - 1 -: WORD_W];
      if (gi == BLOCK_WORDS - 1) begin : g_tail
        assign window_shift[gi] = w_new;
      end else begin : g_body
        assign window_shift[gi] = window_reg[gi + 1];
      end
    end
  endgenerate

  accel_sched_expand u_expand (
    .w_m16 (window_reg[0]),
    .w_m15 (window_reg[1]),
    .w_m7  (window_reg[9]),
    .w_m2  (window_reg[14]),
    .w_new (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      t_reg        <= '0;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        window_reg[i] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      t_reg        <= t_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      if (load) begin
        window_reg <= window_load;
      end else if (shift) begin
        window_reg <= window_shift;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    t_next        = '0;
    wait_cnt_next = '0;
    err_next      = err_reg;
    load          = 1'b0;
    shift         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (blk_valid) begin
          load       = 1'b1;
          state_next = blk_first ? INIT : START;
        end
      end
      INIT:  state_next = START;
      START: state_next = FEED;
      FEED: begin
        shift = 1'b1;
        if (t_reg == T_LAST) begin
          state_next = WAIT;
        end else begin
          t_next = t_reg + 6'd1;
        end
      end
      WAIT: begin
        // hash_done takes priority over a timeout expiring in the same cycle
        if (hash_done) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign blk_ready   = (state_reg == IDLE);
  assign cm_init     = (state_reg == INIT);
  assign cm_enable   = (state_reg == START);
  assign w_valid     = (state_reg == FEED);
  assign w           = w_valid ? window_reg[0] : '0;
  assign w_idx       = w_valid ? t_reg : 6'd0;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_accel_msg_scheduler.sv
// Scoreboard bench for accel_msg_scheduler: stimulus pushes expected cm_*/W events with
// their cycle numbers, a negedge monitor pops and compares whenever the DUT emits one.
module tb_accel_msg_scheduler;

  localparam int DONE_TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         cm_init, cm_enable;
  logic [31:0]  w;
  logic         w_valid;
  logic [5:0]   w_idx;
  logic         hash_done = 1'b0;
  logic         err_timeout;

  accel_msg_scheduler #(.DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .blk_first   (blk_first),
    .cm_init     (cm_init),
    .cm_enable   (cm_enable),
    .w           (w),
    .w_valid     (w_valid),
    .w_idx       (w_idx),
    .hash_done   (hash_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 cm_init, 1 cm_enable, 2 word
    int          cyc;
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          nwords = 0;
  int          blk_count = 0;
  bit          err_exp = 1'b0;
  logic [31:0] cap [64];
  logic [31:0] wm  [64];
  logic [511:0] abc, blk_a, blk_b;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Reference schedule for a block, queued with the cycle each event must appear in.
  task automatic push_block(input int n, input bit first, input logic [511:0] d, input int nw);
    int base;
    for (int t = 0; t < 16; t++) wm[t] = d[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) wm[t] = ssig1(wm[t-2]) + wm[t-7] + ssig0(wm[t-15]) + wm[t-16];
    if (first) exp_q.push_back('{kind: 0, cyc: n + 1, idx: 0, data: 32'h0});
    exp_q.push_back('{kind: 1, cyc: n + (first ? 2 : 1), idx: 0, data: 32'h0});
    base = n + (first ? 3 : 2);
    for (int t = 0; t < nw; t++) exp_q.push_back('{kind: 2, cyc: base + t, idx: t, data: wm[t]});
  endtask

  task automatic check_event(input int kind, input int idx, input logic [31:0] data);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL stream at cycle %0d: got kind=%0d idx=%0d w=%h, required no event", cyc, kind, idx, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == 2 && (e.idx != idx || e.data !== data))) begin
        errors++;
        $display("FAIL stream: got kind=%0d cyc=%0d idx=%0d w=%h, required kind=%0d cyc=%0d idx=%0d w=%h",
                 kind, cyc, idx, data, e.kind, e.cyc, e.idx, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cm_init) check_event(0, 0, 32'h0);
      if (cm_enable) check_event(1, 0, 32'h0);
      if (w_valid) begin
        cap[w_idx] = w;
        nwords++;
        check_event(2, int'(w_idx), w);
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!blk_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready_bound", blk_ready, 1);
  endtask

  // done_delay: 1..DONE_TIMEOUT = WAIT cycle in which hash_done pulses; 0 = never (timeout).
  task automatic run_block(input logic [511:0] d, input bit first, input int done_delay,
                           input bit hold, input bit spur);
    int n, last;
    wait_ready();
    if (spur) begin
      hash_done = 1'b1;
      @(negedge clk);
      hash_done = 1'b0;
      chk("spur_idle_ready", blk_ready, 1);
    end
    blk_valid = 1'b1;
    blk_data  = d;
    blk_first = first;
    n         = cyc;
    nwords    = 0;
    for (int i = 0; i < 64; i++) cap[i] = 32'h0;
    push_block(n, first, d, 64);
    last = n + (first ? 66 : 65);
    blk_count++;
    $display("block %0d accepted at cycle %0d first=%0d done_delay=%0d hold=%0d spur=%0d",
             blk_count, n, first, done_delay, hold, spur);
    for (int c = n + 1; c <= last; c++) begin
      @(negedge clk);
      chk("ready_low_busy", blk_ready, 0);
      if (hold) begin
        blk_valid = 1'b1;
        blk_first = 1'b1;
        for (int i = 0; i < 16; i++) blk_data[32*i +: 32] = $urandom();
      end else begin
        blk_valid = 1'b0;
      end
      hash_done = spur && (c == n + 20);
    end
    if (done_delay > 0) begin
      for (int k = 1; k <= done_delay; k++) begin
        @(negedge clk);
        chk("ready_low_wait", blk_ready, 0);
        hash_done = (k == done_delay);
        if (hold) for (int i = 0; i < 16; i++) blk_data[32*i +: 32] = $urandom();
      end
      @(negedge clk);
      hash_done = 1'b0;
      blk_valid = 1'b0;
      chk("ready_after_done", blk_ready, 1);
    end else begin
      for (int k = 1; k <= DONE_TIMEOUT; k++) begin
        @(negedge clk);
        chk("ready_low_timeout", blk_ready, 0);
        chk("err_before_limit", err_timeout, err_exp);
      end
      @(negedge clk);
      blk_valid = 1'b0;
      err_exp   = 1'b1;
      chk("ready_after_timeout", blk_ready, 1);
    end
    chk("err_timeout_state", err_timeout, err_exp);
    chk("words_per_block", nwords, 64);
  endtask

  task automatic check_abc_words();
    chk("abc_w0", cap[0], 32'h61626380);
    chk("abc_w15", cap[15], 32'h00000018);
    chk("abc_w16", cap[16], 32'h61626380);
    chk("abc_w17", cap[17], 32'h000f0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    for (int i = 0; i < 16; i++) begin
      blk_a[511 - 32*i -: 32] = 32'h9e3779b9 * (i + 1);
      blk_b[511 - 32*i -: 32] = 32'h01234567 ^ (32'h11111111 * i);
    end

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_cm_init", cm_init, 0);
    chk("rst_cm_enable", cm_enable, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w", w, 0);
    chk("rst_w_idx", w_idx, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;

    // "abc" single block
    run_block(abc, 1'b1, 3, 1'b0, 1'b0);
    check_abc_words();

    // two-block message; second block's hash_done lands on the timeout limit cycle
    run_block(blk_a, 1'b1, 2, 1'b0, 1'b0);
    run_block(blk_b, 1'b0, DONE_TIMEOUT, 1'b0, 1'b0);

    // blk_valid held with changing data during FEED/WAIT
    run_block(blk_b, 1'b0, 5, 1'b1, 1'b0);
    run_block(abc, 1'b0, 1, 1'b0, 1'b0);

    // spurious hash_done in IDLE and FEED
    run_block(blk_a, 1'b1, 4, 1'b0, 1'b1);

    // hash_done never arrives, then err_timeout stays sticky
    run_block(abc, 1'b0, 0, 1'b0, 1'b0);
    run_block(blk_b, 1'b1, 2, 1'b0, 1'b0);

    // reset while W30 is on the bus
    wait_ready();
    blk_valid = 1'b1;
    blk_data  = abc;
    blk_first = 1'b1;
    n         = cyc;
    push_block(n, 1'b1, abc, 31);
    blk_count++;
    $display("block %0d accepted at cycle %0d first=1 (reset at W30)", blk_count, n);
    @(negedge clk);
    blk_valid = 1'b0;
    while (cyc < n + 33) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_w_valid", w_valid, 0);
    chk("mid_rst_cm_init", cm_init, 0);
    chk("mid_rst_cm_enable", cm_enable, 0);
    chk("mid_rst_blk_ready", blk_ready, 1);
    chk("mid_rst_w_idx", w_idx, 0);
    chk("mid_rst_err", err_timeout, 0);
    err_exp = 1'b0;
    chk("queue_drained_at_reset", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_block(abc, 1'b1, 3, 1'b0, 1'b0);
    check_abc_words();

    repeat (4) @(negedge clk);
    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
